queue_8b: RTL

- 8-bit FIFO queue: enqueue at the tail, dequeue at the head. It is the first-in-first-out counterpart of the team's 8-bit push/pop stack.
- Serves as the producer/consumer buffer between CPU program I/O and peripherals.
- Port-level behaviour of OUTPUT matches the stack convention: it is driven only on a dequeue cycle.
- Storage is a register array with combinational read, two wrapping pointers and an occupancy counter.

---
 rtl/queue_pkg.sv | 17 +
 rtl/queue_ptr.sv | 40 ++++
 rtl/queue_8b.sv | 127 ++++++++++++
 3 files changed

// File: rtl/queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_pkg
// Description : Shared defaults and word/pointer/count types for queue_8b.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_pkg;

    localparam int QUEUE_DATA_W     = 8;
    localparam int QUEUE_DEPTH_LOG2 = 8;

    typedef logic [QUEUE_DATA_W-1:0]   word_t;
    typedef logic [QUEUE_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [QUEUE_DEPTH_LOG2:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/queue_ptr.sv
`default_nettype none
// ============================================================================
// Module      : queue_ptr
// Description : Wrapping pointer register; advances by one when inc is high.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_ptr
    import queue_pkg::*;
#(
    parameter int WIDTH = $bits(ptr_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Natural overflow of the WIDTH-bit add gives the modulo wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/queue_8b.sv
`default_nettype none
// ============================================================================
// Module      : queue_8b
// Description : Register-array FIFO with combinational head read and an
//               occupancy counter. Define QUEUE_8B_ERR_FLAGS_EN to add sticky
//               OVERFLOW/UNDERFLOW outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_8b
    import queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = QUEUE_DEPTH_LOG2,
    parameter int DATA_W     = QUEUE_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                PUSH,
    input  logic                POP,
    input  logic [DATA_W-1:0]   VALUE,
    output logic [DATA_W-1:0]   OUTPUT,
    output logic [DATA_W-1:0]   Front,
    output logic [DEPTH_LOG2:0] COUNT,
    output logic                EMPTY,
    output logic                FULL
`ifdef QUEUE_8B_ERR_FLAGS_EN
    ,
    output logic                OVERFLOW,
    output logic                UNDERFLOW
`endif
);

    localparam int c_entries = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_cnt = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_one_cnt  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DATA_W-1:0]     mem_q [0:c_entries-1];
    logic [DEPTH_LOG2-1:0] head_q;
    logic [DEPTH_LOG2-1:0] tail_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic [DATA_W-1:0]     w_head_word;

    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == c_full_cnt);
    // A pop in the same cycle frees the slot a full-queue push lands in.
    assign w_push_ok   = PUSH & (~w_full | POP);
    assign w_pop_ok    = POP & ~w_empty;
    assign w_head_word = mem_q[head_q];

    queue_ptr #(.WIDTH(DEPTH_LOG2)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_pop_ok),
        .ptr (head_q)
    );

    queue_ptr #(.WIDTH(DEPTH_LOG2)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_push_ok),
        .ptr (tail_q)
    );

    always_comb begin
        count_d = count_q;
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + c_one_cnt;
            2'b01:   count_d = count_q - c_one_cnt;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; contents beyond COUNT are don't-care.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[tail_q] <= VALUE;
        end
    end

    assign OUTPUT = w_pop_ok ? w_head_word : '0;
    assign Front  = w_empty  ? '0 : w_head_word;
    assign COUNT  = count_q;
    assign EMPTY  = w_empty;
    assign FULL   = w_full;

`ifdef QUEUE_8B_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (PUSH & ~w_push_ok);
        underflow_d = underflow_q | (POP & ~w_pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`else
    // Without the flags, rejected operations simply have no effect.
`endif

endmodule
`default_nettype wire
